// File: rtl/fetch_pkg.sv
`default_nettype none
// -----------------------------------------------------------------
// fetch_pkg : shared constants and types for the fetch unit
// Rev 1.0
// -----------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] IMEM_OOB_WORD    = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// -----------------------------------------------------------------
// fetch_fifo : queue of {pc, inst} entries with flush
// Rev 1.0
// -----------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH) + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == c_CW'(DEPTH));
  assign w_pop  = pop && !empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_push = push && (!full || w_pop);
  assign head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// -----------------------------------------------------------------
// fetch_unit : PC owner, imem address and fetch queue toward decode
// Optional macro FETCH_STATS_EN adds stat_fetched / stat_stall. Rev 1.0
// -----------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
`ifdef FETCH_STATS_EN
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall,
`endif
  output logic        fault,
  output logic [31:0] fault_pc
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         r_fault;
  logic         w_fault_nxt;
  logic [31:0]  r_fault_pc;
  logic [31:0]  w_fault_pc_nxt;

  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;
  logic         w_flush;
  fetch_entry_t w_head;
  fetch_entry_t w_wdata;

  assign imem_addr  = r_pc;
  assign inst_valid = !w_empty;
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;
  assign fault      = r_fault;
  assign fault_pc   = r_fault_pc;
  assign w_pop      = inst_valid && inst_ready;
  assign w_wdata    = {r_pc, imem_rd};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .wdata (w_wdata),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_fault    <= w_fault_nxt;
      r_fault_pc <= w_fault_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_fault_nxt    = r_fault;
    w_fault_pc_nxt = r_fault_pc;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    // A redirect wins over everything; the flush also discards a same-cycle pop.
    if (redirect_valid) begin
      w_flush     = 1'b1;
      w_pc_nxt    = {redirect_pc[31:2], 2'b00};
      w_fault_nxt = 1'b0;
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (!w_full || w_pop) begin
            if (imem_rd == IMEM_OOB_WORD) begin
              w_fault_nxt    = 1'b1;
              w_fault_pc_nxt = r_pc;
              w_state_nxt    = HALT;
            end else begin
              w_push   = 1'b1;
              w_pc_nxt = r_pc + 32'd4;
            end
          end
        end
        HALT: begin
          w_state_nxt = HALT;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_stall;
  logic        w_stall;

  assign w_stall      = (r_state == RUN) && !redirect_valid && w_full && !w_pop;
  assign stat_fetched = r_stat_fetched;
  assign stat_stall   = r_stat_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_fetched <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_push) begin
        r_stat_fetched <= r_stat_fetched + 32'd1;
      end
      if (w_stall) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
